// File: rtl/atomic_pkg.sv
// rtl/atomic_pkg.sv - funct5 encodings, size codes and FSM state type for the A-extension unit
package atomic_pkg;

    // funct5 encodings of the A extension
    localparam logic [4:0] F5_LR   = 5'b00010;
    localparam logic [4:0] F5_SC   = 5'b00011;
    localparam logic [4:0] F5_SWAP = 5'b00001;
    localparam logic [4:0] F5_ADD  = 5'b00000;
    localparam logic [4:0] F5_XOR  = 5'b00100;
    localparam logic [4:0] F5_AND  = 5'b01100;
    localparam logic [4:0] F5_OR   = 5'b01000;
    localparam logic [4:0] F5_MIN  = 5'b10000;
    localparam logic [4:0] F5_MAX  = 5'b10100;
    localparam logic [4:0] F5_MINU = 5'b11000;
    localparam logic [4:0] F5_MAXU = 5'b11100;

    // funct3 access sizes
    localparam logic [2:0] SIZE_W = 3'b010;
    localparam logic [2:0] SIZE_D = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT_READ,
        S_COMPUTE,
        S_WRITE,
        S_WAIT_WRITE,
        S_DONE
    } state_t;

endpackage

// File: rtl/amo_alu.sv
// rtl/amo_alu.sv - combinational AMO arithmetic with 32-bit word mode
module amo_alu
    import atomic_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            word,
    output logic [XLEN-1:0] y
);

    logic [31:0]     aw;
    logic [31:0]     bw;
    logic [31:0]     yw;
    logic [XLEN-1:0] yd;

    // Compute both the word and full-width result; word mode zeroes the upper bits.
    // Unknown encodings fall through to the loaded value so memory is rewritten unchanged.
    always_comb begin
        aw = a[31:0];
        bw = b[31:0];
        yw = aw;
        yd = a;
        case (op)
            F5_SWAP: begin
                yw = bw;
                yd = b;
            end
            F5_ADD: begin
                yw = aw + bw;
                yd = a + b;
            end
            F5_XOR: begin
                yw = aw ^ bw;
                yd = a ^ b;
            end
            F5_AND: begin
                yw = aw & bw;
                yd = a & b;
            end
            F5_OR: begin
                yw = aw | bw;
                yd = a | b;
            end
            F5_MIN: begin
                yw = ($signed(aw) < $signed(bw)) ? aw : bw;
                yd = ($signed(a) < $signed(b)) ? a : b;
            end
            F5_MAX: begin
                yw = ($signed(aw) > $signed(bw)) ? aw : bw;
                yd = ($signed(a) > $signed(b)) ? a : b;
            end
            F5_MINU: begin
                yw = (aw < bw) ? aw : bw;
                yd = (a < b) ? a : b;
            end
            F5_MAXU: begin
                yw = (aw > bw) ? aw : bw;
                yd = (a > b) ? a : b;
            end
            default: begin
                yw = aw;
                yd = a;
            end
        endcase
        y = yd;
        if (word) begin
            y       = '0;
            y[31:0] = yw;
        end
    end

endmodule

// File: rtl/amo_engine.sv
// rtl/amo_engine.sv - LR/SC/AMO execution unit with internal reservation; optional timeout via ATOMIC_RSV_TIMEOUT_EN
module amo_engine
    import atomic_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int RSV_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [4:0]      funct5,
    input  logic [2:0]      funct3,
    input  logic            aq,
    input  logic            rl,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] src_data,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [2:0]      mem_size,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    input  logic            snoop_valid,
    input  logic [XLEN-1:0] snoop_addr,
    input  logic            rsv_clear,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            busy,
    output logic            misaligned
);

    // Reservation granule is one XLEN-sized word
    localparam logic [XLEN-1:0] GRAN_MASK = ~(XLEN'(XLEN / 8 - 1));

    state_t          state;
    logic [4:0]      op_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] src_q;
    logic [XLEN-1:0] rdata_q;
    // Ordering bits are kept only for visibility; a single-outstanding unit needs no fencing
    logic [1:0]      ord_bits_unused;

    logic            rsv_valid;
    logic [XLEN-1:0] rsv_addr;
    logic            rsv_expire;

    logic            fault;
    logic            word_q;
    logic            rsv_hit_now;
    logic            sc_start;
    logic            lr_set;
    logic            snoop_kill;
    logic            snoop_new;
    logic [XLEN-1:0] snoop_gran;
    logic [XLEN-1:0] alu_y;

    // Sign-extend a .W value from bit 31; .D values pass through
    function automatic logic [XLEN-1:0] fix_w(input logic [XLEN-1:0] v, input logic w);
        logic [XLEN-1:0] r;
        r = v;
        if (w) begin
            r       = {XLEN{v[31]}};
            r[31:0] = v[31:0];
        end
        return r;
    endfunction

    // Alignment check on the incoming request; .D on RV32 and unknown sizes are faults
    always_comb begin
        fault = 1'b1;
        if (funct3 == SIZE_W) begin
            fault = (addr[1:0] != 2'b00);
        end else if ((funct3 == SIZE_D) && (XLEN == 64)) begin
            fault = (addr[2:0] != 3'b000);
        end
    end

    assign word_q      = (f3_q == SIZE_W);
    assign rsv_hit_now = rsv_valid && ((addr & GRAN_MASK) == rsv_addr);
    assign sc_start    = (state == S_IDLE) && start && !fault && (funct5 == F5_SC);
    assign lr_set      = (state == S_WAIT_READ) && mem_ready && (op_q == F5_LR);
    assign snoop_gran  = snoop_addr & GRAN_MASK;
    assign snoop_kill  = snoop_valid && (snoop_gran == rsv_addr);
    assign snoop_new   = snoop_valid && (snoop_gran == (addr_q & GRAN_MASK));
    assign busy        = (state != S_IDLE);

    amo_alu #(
        .XLEN(XLEN)
    ) u_alu (
        .op   (op_q),
        .a    (rdata_q),
        .b    (src_q),
        .word (word_q),
        .y    (alu_y)
    );

    // Main sequencer: captures the request, drives the memory port and produces result/done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            op_q            <= '0;
            f3_q            <= '0;
            addr_q          <= '0;
            src_q           <= '0;
            rdata_q         <= '0;
            ord_bits_unused <= '0;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_size        <= '0;
            result          <= '0;
            done            <= 1'b0;
            misaligned      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q            <= funct5;
                        f3_q            <= funct3;
                        addr_q          <= addr;
                        src_q           <= src_data;
                        ord_bits_unused <= {aq, rl};
                        mem_size        <= funct3;
                        result          <= '0;
                        if (fault) begin
                            misaligned <= 1'b1;
                            done       <= 1'b1;
                            state      <= S_DONE;
                        end else if (funct5 == F5_SC) begin
                            if (rsv_hit_now) begin
                                mem_req   <= 1'b1;
                                mem_we    <= 1'b1;
                                mem_addr  <= addr;
                                mem_wdata <= src_data;
                                state     <= S_WRITE;
                            end else begin
                                result <= XLEN'(1);
                                done   <= 1'b1;
                                state  <= S_DONE;
                            end
                        end else begin
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= addr;
                            state    <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    state <= S_WAIT_READ;
                end
                S_WAIT_READ: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        rdata_q <= mem_rdata;
                        if (op_q == F5_LR) begin
                            result <= fix_w(mem_rdata, word_q);
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            state <= S_COMPUTE;
                        end
                    end
                end
                S_COMPUTE: begin
                    mem_req   <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_wdata <= alu_y;
                    state     <= S_WRITE;
                end
                S_WRITE: begin
                    state <= S_WAIT_WRITE;
                end
                S_WAIT_WRITE: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        result  <= (op_q == F5_SC) ? '0 : fix_w(rdata_q, word_q);
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    misaligned <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Reservation register: an LR completing alongside a kill source ends invalid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsv_valid <= 1'b0;
            rsv_addr  <= '0;
        end else if (lr_set) begin
            rsv_valid <= !(rsv_clear || snoop_new);
            rsv_addr  <= addr_q & GRAN_MASK;
        end else if (rsv_clear || snoop_kill || sc_start || rsv_expire) begin
            rsv_valid <= 1'b0;
        end
    end

`ifdef ATOMIC_RSV_TIMEOUT_EN
    localparam int CW = $clog2(RSV_TIMEOUT + 1);

    logic [CW-1:0] rsv_count;

    // Lifetime counter: reloads on LR, counts down while the reservation is held
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsv_count <= '0;
        end else if (lr_set) begin
            rsv_count <= CW'(RSV_TIMEOUT);
        end else if (rsv_valid && (rsv_count != '0)) begin
            rsv_count <= rsv_count - 1'b1;
        end
    end

    assign rsv_expire = rsv_valid && (rsv_count == CW'(1));
`else
    localparam int unused_rsv_timeout = RSV_TIMEOUT;

    assign rsv_expire = 1'b0;
`endif

endmodule

// File: tb/tb_amo_engine.sv
// tb/tb_amo_engine.sv - directed vector bench for amo_engine on RV64
module tb_amo_engine;

    localparam logic [4:0] LR   = 5'b00010;
    localparam logic [4:0] SC   = 5'b00011;
    localparam logic [4:0] SWP  = 5'b00001;
    localparam logic [4:0] ADD  = 5'b00000;
    localparam logic [4:0] XOR_ = 5'b00100;
    localparam logic [4:0] AND_ = 5'b01100;
    localparam logic [4:0] OR_  = 5'b01000;
    localparam logic [4:0] MIN  = 5'b10000;
    localparam logic [4:0] MAX  = 5'b10100;
    localparam logic [4:0] MINU = 5'b11000;
    localparam logic [4:0] MAXU = 5'b11100;
    localparam logic [4:0] BAD  = 5'b11111;
    localparam logic [2:0] W    = 3'b010;
    localparam logic [2:0] D    = 3'b011;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  funct5;
    logic [2:0]  funct3;
    logic        aq, rl;
    logic [63:0] addr, src_data;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [2:0]  mem_size;
    logic [63:0] mem_rdata;
    logic        mem_ready;
    logic        snoop_valid;
    logic [63:0] snoop_addr;
    logic        rsv_clear;
    logic [63:0] result;
    logic        done, busy, misaligned;

    int total = 0;
    int bad = 0;
    int req_age;
    int extra_wait = 0;
    logic hold = 1'b0;

    always #5 clk = ~clk;

    amo_engine #(.XLEN(64), .RSV_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .start(start), .funct5(funct5), .funct3(funct3),
        .aq(aq), .rl(rl), .addr(addr), .src_data(src_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .rsv_clear(rsv_clear),
        .result(result), .done(done), .busy(busy), .misaligned(misaligned)
    );

    // Memory responder: ready after 1+extra_wait cycles of mem_req; hold stalls writes
    always @(posedge clk or posedge reset) begin
        if (reset) req_age <= 0;
        else       req_age <= mem_req ? req_age + 1 : 0;
    end
    assign mem_ready = mem_req && !(hold && mem_we) && (req_age >= 1 + extra_wait);

    typedef struct {
        logic [4:0]  f5;
        logic [2:0]  f3;
        logic [63:0] a;
        logic [63:0] src;
        logic [63:0] rd;
        int          wt;
        logic [63:0] res;
        logic        mis;
        logic        req;
        logic        wr;
        logic [63:0] wd;
        int          cyc;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input logic [4:0] f5, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] s, input logic [63:0] rd, input int wt,
                           input logic [63:0] res, input logic mis, input logic req,
                           input logic wr, input logic [63:0] wd, input int cyc);
        vec_t v;
        v.f5 = f5; v.f3 = f3; v.a = a; v.src = s; v.rd = rd; v.wt = wt;
        v.res = res; v.mis = mis; v.req = req; v.wr = wr; v.wd = wd; v.cyc = cyc;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic do_op(input logic [4:0] f5, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] s, input logic [63:0] rd, input int wt, input logic sn,
                         output int cyc, output logic [63:0] res, output logic mis,
                         output logic req_seen, output logic wr, output logic [63:0] wd);
        @(posedge clk); #1;
        funct5 = f5; funct3 = f3; addr = a; src_data = s; mem_rdata = rd;
        extra_wait = wt; aq = 1'b1; rl = 1'b0; start = 1'b1;
        if (sn) begin
            snoop_valid = 1'b1;
            snoop_addr  = a;
        end
        cyc = -1; res = '0; mis = 1'b0; req_seen = 1'b0; wr = 1'b0; wd = '0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (mem_req) req_seen = 1'b1;
            if (mem_req && mem_we && mem_ready) begin
                wr = 1'b1;
                wd = mem_wdata;
            end
            if (done) begin
                cyc = c;
                res = result;
                mis = misaligned;
                break;
            end
        end
        snoop_valid = 1'b0;
    endtask

    task automatic pulse_snoop(input logic [63:0] a);
        @(posedge clk); #1;
        snoop_valid = 1'b1;
        snoop_addr  = a;
        @(posedge clk); #1;
        snoop_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    int          cy;
    logic [63:0] r, wd;
    logic        m, rq, w;

    initial begin
        reset = 1'b1; start = 1'b0; funct5 = '0; funct3 = '0; aq = 1'b0; rl = 1'b0;
        addr = '0; src_data = '0; mem_rdata = '0; snoop_valid = 1'b0; snoop_addr = '0;
        rsv_clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", {59'd0, done, busy, misaligned, mem_req, mem_we}, 64'd0);
        chk("rst_addr", mem_addr, 64'd0);
        chk("rst_wdata", mem_wdata, 64'd0);
        chk("rst_size", {61'd0, mem_size}, 64'd0);
        chk("rst_result", result, 64'd0);
        reset = 1'b0;

        //      f5    f3 addr      src                    rdata                  wt result                 mis req wr wdata                  cyc
        add_vec(ADD,  W, 64'h10,  64'h1,                 64'h7FFFFFFF,          0, 64'h7FFFFFFF,          0, 1, 1, 64'h80000000,          6);
        add_vec(MIN,  W, 64'h10,  64'h5,                 64'hFFFFFFFF,          0, 64'hFFFFFFFFFFFFFFFF,  0, 1, 1, 64'hFFFFFFFF,          6);
        add_vec(MINU, W, 64'h10,  64'h5,                 64'hFFFFFFFF,          0, 64'hFFFFFFFFFFFFFFFF,  0, 1, 1, 64'h5,                 6);
        add_vec(ADD,  D, 64'h18,  64'h1,                 64'hFFFFFFFFFFFFFFFF,  2, 64'hFFFFFFFFFFFFFFFF,  0, 1, 1, 64'h0,                 10);
        add_vec(MAX,  D, 64'h18,  64'h3,                 64'h8000000000000000,  0, 64'h8000000000000000,  0, 1, 1, 64'h3,                 6);
        add_vec(MAXU, D, 64'h18,  64'h3,                 64'h8000000000000000,  0, 64'h8000000000000000,  0, 1, 1, 64'h8000000000000000,  6);
        add_vec(SWP,  W, 64'h14,  64'hAAAAAAAA87654321,  64'h12345678,          0, 64'h12345678,          0, 1, 1, 64'h87654321,          6);
        add_vec(XOR_, D, 64'h18,  64'hFF00,              64'hF0F0,              0, 64'hF0F0,              0, 1, 1, 64'h0FF0,              6);
        add_vec(AND_, W, 64'h10,  64'h0F0F0F0F,          64'hFFFF00FF,          0, 64'hFFFFFFFFFFFF00FF,  0, 1, 1, 64'h0F0F000F,          6);
        add_vec(OR_,  D, 64'h18,  64'h100,               64'h1,                 0, 64'h1,                 0, 1, 1, 64'h101,               6);
        add_vec(BAD,  D, 64'h18,  64'h1,                 64'hDEAD,              0, 64'hDEAD,              0, 1, 1, 64'hDEAD,              6);
        add_vec(LR,   W, 64'h102, 64'h0,                 64'h0,                 0, 64'h0,                 1, 0, 0, 64'h0,                 1);
        add_vec(ADD,  D, 64'h14,  64'h1,                 64'h0,                 0, 64'h0,                 1, 0, 0, 64'h0,                 1);
        add_vec(LR,   D, 64'h100, 64'h0,                 64'h55,                0, 64'h55,                0, 1, 0, 64'h0,                 3);
        add_vec(SC,   W, 64'h104, 64'h9,                 64'h0,                 0, 64'h0,                 0, 1, 1, 64'h9,                 3);
        add_vec(SC,   W, 64'h104, 64'h9,                 64'h0,                 0, 64'h1,                 0, 0, 0, 64'h0,                 1);
        add_vec(LR,   W, 64'h40,  64'h0,                 64'h80000000,          1, 64'hFFFFFFFF80000000,  0, 1, 0, 64'h0,                 4);
        add_vec(SC,   D, 64'h48,  64'h3,                 64'h0,                 0, 64'h1,                 0, 0, 0, 64'h0,                 1);
        add_vec(LR,   D, 64'h300, 64'h0,                 64'h7,                 0, 64'h7,                 0, 1, 0, 64'h0,                 3);
        add_vec(LR,   W, 64'h301, 64'h0,                 64'h0,                 0, 64'h0,                 1, 0, 0, 64'h0,                 1);
        add_vec(SC,   D, 64'h300, 64'h77,                64'h0,                 0, 64'h0,                 0, 1, 1, 64'h77,                3);

        foreach (vq[i]) begin
            do_op(vq[i].f5, vq[i].f3, vq[i].a, vq[i].src, vq[i].rd, vq[i].wt, 1'b0, cy, r, m, rq, w, wd);
            chk($sformatf("v%0d_cyc", i), 64'(cy), 64'(vq[i].cyc));
            chk($sformatf("v%0d_res", i), r, vq[i].res);
            chk($sformatf("v%0d_mis", i), {63'd0, m}, {63'd0, vq[i].mis});
            chk($sformatf("v%0d_req", i), {63'd0, rq}, {63'd0, vq[i].req});
            chk($sformatf("v%0d_wr", i), {63'd0, w}, {63'd0, vq[i].wr});
            if (vq[i].wr) chk($sformatf("v%0d_wdata", i), wd, vq[i].wd);
        end

        // Matching snoop kills the reservation
        do_op(LR, D, 64'h200, 64'h0, 64'h1, 0, 1'b0, cy, r, m, rq, w, wd);
        pulse_snoop(64'h200);
        do_op(SC, D, 64'h200, 64'h5, 64'h0, 0, 1'b0, cy, r, m, rq, w, wd);
        chk("snoop_hit_res", r, 64'h1);
        chk("snoop_hit_req", {63'd0, rq}, 64'd0);

        // Snoop to a different granule leaves it alone
        do_op(LR, D, 64'h200, 64'h0, 64'h1, 0, 1'b0, cy, r, m, rq, w, wd);
        pulse_snoop(64'h208);
        do_op(SC, D, 64'h200, 64'h5, 64'h0, 0, 1'b0, cy, r, m, rq, w, wd);
        chk("snoop_other_res", r, 64'h0);
        chk("snoop_other_wdata", wd, 64'h5);

        // Snoop in the same cycle as the SC start does not affect that SC
        do_op(LR, D, 64'h200, 64'h0, 64'h1, 0, 1'b0, cy, r, m, rq, w, wd);
        do_op(SC, D, 64'h200, 64'h6, 64'h0, 0, 1'b1, cy, r, m, rq, w, wd);
        chk("snoop_same_res", r, 64'h0);

        // Matching snoop while the LR completes: clear wins over set
        do_op(LR, D, 64'h220, 64'h0, 64'h1, 0, 1'b1, cy, r, m, rq, w, wd);
        do_op(SC, D, 64'h220, 64'h6, 64'h0, 0, 1'b0, cy, r, m, rq, w, wd);
        chk("lr_snoop_prio_res", r, 64'h1);

        // rsv_clear kills the reservation
        do_op(LR, D, 64'h240, 64'h0, 64'h1, 0, 1'b0, cy, r, m, rq, w, wd);
        @(posedge clk); #1 rsv_clear = 1'b1;
        @(posedge clk); #1 rsv_clear = 1'b0;
        do_op(SC, D, 64'h240, 64'h6, 64'h0, 0, 1'b0, cy, r, m, rq, w, wd);
        chk("rsv_clear_res", r, 64'h1);

        // Reservation lifetime: prompt SC passes, late SC fails only with the timeout built in
        do_op(LR, D, 64'h500, 64'h0, 64'h1, 0, 1'b0, cy, r, m, rq, w, wd);
        do_op(SC, D, 64'h500, 64'h6, 64'h0, 0, 1'b0, cy, r, m, rq, w, wd);
        chk("timeout_early_res", r, 64'h0);
        do_op(LR, D, 64'h500, 64'h0, 64'h1, 0, 1'b0, cy, r, m, rq, w, wd);
        repeat (3) @(posedge clk);
        do_op(SC, D, 64'h500, 64'h6, 64'h0, 0, 1'b0, cy, r, m, rq, w, wd);
`ifdef ATOMIC_RSV_TIMEOUT_EN
        chk("timeout_late_res", r, 64'h1);
`else
        chk("timeout_late_res", r, 64'h0);
`endif

        // Reset asserted during WAIT_WRITE drops every output and the reservation
        do_op(LR, D, 64'h600, 64'h0, 64'h1234, 0, 1'b0, cy, r, m, rq, w, wd);
        hold = 1'b1;
        @(posedge clk); #1;
        funct5 = ADD; funct3 = D; addr = 64'h600; src_data = 64'h1; mem_rdata = 64'h1234;
        extra_wait = 0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (mem_we) break;
            @(posedge clk); #1;
        end
        chk("rst_mid_we", {63'd0, mem_we}, 64'd1);
        @(posedge clk); #1;
        chk("rst_mid_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_ctl", {59'd0, done, busy, misaligned, mem_req, mem_we}, 64'd0);
        chk("rst_mid_addr", mem_addr, 64'd0);
        chk("rst_mid_wdata", mem_wdata, 64'd0);
        chk("rst_mid_size", {61'd0, mem_size}, 64'd0);
        chk("rst_mid_result", result, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        hold = 1'b0;
        do_op(SC, D, 64'h600, 64'h6, 64'h0, 0, 1'b0, cy, r, m, rq, w, wd);
        chk("rst_mid_sc_res", r, 64'h1);
        chk("rst_mid_sc_req", {63'd0, rq}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
